// File: rtl/seq_alu.sv
// Clocked ALU with registered results, start/done handshake and WIDTH-cycle
// iterative shift-add multiply / restoring divide feeding architectural HI/LO.
module seq_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ins,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 dz_q, dz_d;

    // Single-cycle datapath
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;

    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} - {1'b0, B};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (ins)
            4'd1: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
            end
            4'd2: begin
                alu_res   = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];
            end
            4'd5: alu_res = A | B;
            4'd6: alu_res = A & B;
            4'd7: alu_res = ~A;
            4'd8: alu_res = A ^ B;
            4'd9: begin
                alu_res[0] = $signed(A) < $signed(B);
                alu_res[1] = A == B;
                alu_res[2] = $signed(A) > $signed(B);
            end
            default: alu_res = '0;
        endcase
    end

    // Iteration step. acc holds {partial, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; opnd is multiplicand/divisor.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, opnd_q};
    // A zero divisor never goes negative, so the quotient fills with ones and
    // the remainder ends up as the untouched dividend.
    assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    assign step = is_div_q ? div_next : mul_next;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        out_d    = out_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ins == 4'd3 || ins == 4'd4) begin
                        state_d  = RUN;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (ins == 4'd4);
                        opnd_d   = (ins == 4'd4) ? B : A;
                        acc_d    = {{WIDTH{1'b0}}, ((ins == 4'd4) ? A : B)};
                    end else begin
                        out_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        carry_d = alu_carry;
                        dz_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    hi_d    = step[2*WIDTH-1:WIDTH];
                    lo_d    = step[WIDTH-1:0];
                    out_d   = step[WIDTH-1:0];
                    zero_d  = (step[WIDTH-1:0] == '0);
                    carry_d = 1'b0;
                    dz_d    = is_div_q && (opnd_q == '0);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dz_q     <= dz_d;
        end
    end

    assign out   = out_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign dz    = dz_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked successor to the team's combinational 16-bit ALU. It keeps the same opcode map and adds registered results, a start/done handshake and iterative multiply/divide engines, so a wide datapath can use it without a long combinational multiplier/divider path. Multiply and divide take WIDTH cycles. All other operations complete in one cycle. HI/LO are architectural registers that persist across non-multiply/divide operations. The block sits between the register-file read ports and the writeback mux of the datapath.

## Interface
- `WIDTH`, default 16: operand/result width; legal values are 4 and above.
- `clk` in, 1 bit: the single clock; all state updates on the rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: request; accepted on a rising edge when `start && !busy`.
- `ins` in, 4 bits: opcode, sampled at acceptance.
- `A`, `B` in, WIDTH bits each: operands, sampled at acceptance.
- `out` out, WIDTH bits: registered result.
- `hi`, `lo` out, WIDTH bits each: HI/LO registers.
- `busy` out, 1 bit: multi-cycle operation in progress; `start` is ignored while high.
- `done` out, 1 bit: one-cycle pulse; `out`, `hi`, `lo` and the flags are valid from this cycle onward.
- `zero` out, 1 bit: `out == 0` for the completed operation.
- `carry` out, 1 bit: add carry-out; for sub, borrow (set when A < B unsigned); 0 for all other opcodes.
- `dz` out, 1 bit: the completed operation was a divide with B == 0.

## Operation
- Opcodes:
  - 0: nop, `out` = 0
  - 1: add, A+B mod 2^WIDTH
  - 2: sub, A−B mod 2^WIDTH
  - 3: mul, unsigned; {hi,lo} = A*B; `out` = lo
  - 4: div, unsigned; lo = quotient, hi = remainder; `out` = lo
  - 5: or
  - 6: and
  - 7: not A
  - 8: xor
  - 9: cmp, signed two's complement; `out[0]` = lt, `out[1]` = eq, `out[2]` = gt, other bits 0
  - 10–15: `out` = 0
- `hi`/`lo` change only on completion of opcode 3 or 4. Every other opcode leaves them unchanged.
- FSM states are IDLE and RUN.
  - IDLE with accept of opcode 3 or 4: load operands and a partial-result register, set counter = WIDTH, go to RUN, `busy` = 1.
  - IDLE with accept of any other opcode: register the result and flags, `done` = 1 on the next cycle, stay in IDLE.
  - RUN: perform one iteration per edge and decrement the counter. The edge on which the counter reaches 0 writes `out`/`hi`/`lo`/flags, pulses `done`, and returns to IDLE with `busy` = 0.
- Multiply is a shift-add of one multiplier bit per cycle, with a 2·WIDTH accumulator.
- Divide is restoring division, one quotient bit per cycle.
- Divide by zero still runs WIDTH cycles and returns lo = all ones, hi = A, `dz` = 1.
- `out` and the flags hold their values until the next completion.
- A `start` while `busy` is dropped, with no queueing and no effect.
- `start` during the `done` cycle (state IDLE) is accepted, so back-to-back operations are allowed.

## Timing
- Reset (asynchronous, takes effect immediately): `out` = `hi` = `lo` = 0, `busy` = `done` = `zero` = `carry` = `dz` = 0, state IDLE, counter 0.
- Accept edge is E0.
  - Single-cycle opcodes: `done` is high in the cycle after E0, latency 1.
  - Opcodes 3/4: `busy` is high from after E0 through edge E_WIDTH; `done` and results appear after E_WIDTH, latency WIDTH.
- `done` is never high for two consecutive cycles unless a new operation was accepted during the `done` cycle.
- Reset asserted mid-RUN aborts the operation: no `done` pulse, HI/LO cleared, and the next accepted start behaves normally.
- `busy` and `done` are never high in the same cycle.

## Test plan
All scenarios use WIDTH = 16.
- **Reset values.** Assert `rst` asynchronously between edges → all outputs are 0 immediately and `busy` = 0.
- **Add and sub.** Add 0xFFFF+0x0001 → `done` one cycle after accept, `out` = 0x0000, `zero` = 1, `carry` = 1. Then sub 0x0003−0x0005 → `out` = 0xFFFE, `carry` = 1, `zero` = 0.
- **Multiply.** Mul 0x1234*0x5678 → `busy` high for 16 cycles, `done` exactly 16 cycles after accept, `hi` = 0x0626, `lo` = `out` = 0x0060. A `start` with add issued at cycle 5 is ignored.
- **Divide.**
  - Div 100/7 → `lo` = 0x000E, `hi` = 0x0002, `dz` = 0.
  - Div 0x1234/0 → `lo` = 0xFFFF, `hi` = 0x1234, `dz` = 1, latency 16.
- **Compare and HI/LO retention.** Cmp 0x8000 vs 0x0001 → `out` = 0x0001. Cmp 5 vs 5 → `out` = 0x0002. Then AND 0xF0F0&0x0FF0 → `out` = 0x00F0, with `hi`/`lo` unchanged from the preceding multiply/divide.
- **Reset mid-divide.** Start a div, assert `rst` at cycle 5, deassert → no `done` pulse, `busy` = 0, `hi` = `lo` = 0. A following add 2+3 returns `out` = 0x0005 with latency 1.
